// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg
// Shared parity modes, receiver state encoding and baud mid-point helper.
// Revision: 1.0
// ============================================================================
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic int mid_of(input int clk_div);
    return clk_div / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_if.sv
`default_nettype none
// ============================================================================
// uart_rx_param_if
// Received-word valid/ready bus with error and overrun flags.
// Revision: 1.0
// ============================================================================
interface uart_rx_param_if #(
  parameter int p_DATA_BITS = 8
);

  logic [p_DATA_BITS-1:0] data;
  logic                   valid;
  logic                   ready;
  logic                   parity_err;
  logic                   frame_err;
  logic                   overrun;

  modport master (
    output data, valid, parity_err, frame_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_bit_sampler.sv
`default_nettype none
// ============================================================================
// uart_bit_sampler
// rx synchroniser, baud counter and 3-sample majority with decide/wrap strobes.
// Revision: 1.0
// ============================================================================
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int p_CLK_DIV = 104
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  input  logic i_run,
  output logic o_rx_s,
  output logic o_bit,
  output logic o_decide,
  output logic o_wrap
);

  localparam int c_CNT_W = $clog2(p_CLK_DIV);
  localparam int c_MID   = mid_of(p_CLK_DIV);

  localparam logic [c_CNT_W-1:0] c_S0   = c_CNT_W'(c_MID - 1);
  localparam logic [c_CNT_W-1:0] c_S1   = c_CNT_W'(c_MID);
  localparam logic [c_CNT_W-1:0] c_DEC  = c_CNT_W'(c_MID + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(p_CLK_DIV - 1);

  logic [1:0]         r_sync;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_s0;
  logic               r_s1;
  logic               w_rx_s;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_s0   <= 1'b1;
      r_s1   <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      // Held at zero while idle so the first START cycle sees count 0
      if (!i_run || (r_cnt == c_LAST)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_run && (r_cnt == c_S0)) r_s0 <= w_rx_s;
      if (i_run && (r_cnt == c_S1)) r_s1 <= w_rx_s;
    end
  end

  // Third sample is the live value at the decision count
  assign o_bit    = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign o_rx_s   = w_rx_s;
  assign o_decide = i_run && (r_cnt == c_DEC);
  assign o_wrap   = i_run && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// uart_rx_param
// Parametrised UART receiver: frame FSM, parity/stop checks, output register.
// Revision: 1.0
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int p_CLK_DIV   = 104,
  parameter int p_DATA_BITS = 8,
  parameter int p_PARITY    = 0,
  parameter int p_STOP_BITS = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  uart_rx_param_if.master   rx_bus
);

  localparam int c_IDX_W  = $clog2(p_DATA_BITS + 1);
  localparam bit c_HAS_PAR = (p_PARITY != PAR_NONE);

  localparam logic [c_IDX_W-1:0] c_NDATA     = c_IDX_W'(p_DATA_BITS);
  localparam logic [c_IDX_W-1:0] c_LAST_STOP = c_IDX_W'(p_STOP_BITS - 1);

  state_t                 r_state;
  logic [c_IDX_W-1:0]     r_idx;
  logic [p_DATA_BITS-1:0] r_shift;
  logic [p_DATA_BITS-1:0] r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_armed;

  logic w_run;
  logic w_rx_s;
  logic w_bit;
  logic w_decide;
  logic w_wrap;
  logic w_odd;
  logic w_par_exp;
  logic w_complete;
  logic w_ferr_final;

  assign w_run        = (r_state != ST_IDLE);
  assign w_odd        = (p_PARITY == PAR_ODD);
  assign w_par_exp    = (^r_shift) ^ w_odd;
  assign w_complete   = (r_state == ST_STOP) && w_decide && (r_idx == c_LAST_STOP);
  assign w_ferr_final = r_ferr | ~w_bit;

  uart_bit_sampler #(
    .p_CLK_DIV (p_CLK_DIV)
  ) u_sampler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_rx     (i_rx),
    .i_run    (w_run),
    .o_rx_s   (w_rx_s),
    .o_bit    (w_bit),
    .o_decide (w_decide),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_armed      <= 1'b1;
    end else begin
      if (r_valid && rx_bus.ready) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
      // A completion coinciding with a handshake reloads and keeps valid high
      if (w_complete) begin
        if (!r_valid || rx_bus.ready) begin
          r_data       <= r_shift;
          r_parity_err <= r_perr;
          r_frame_err  <= w_ferr_final;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= ST_START;
            r_idx   <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_decide && w_bit) begin
            r_state <= ST_IDLE;
          end else if (w_wrap) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // LSB arrives first, so it ends up in bit 0 after the last shift
          if (w_decide) begin
            r_shift <= {w_bit, r_shift[p_DATA_BITS-1:1]};
            r_idx   <= r_idx + 1'b1;
          end
          if (w_wrap && (r_idx == c_NDATA)) begin
            r_idx <= '0;
            if (c_HAS_PAR) r_state <= ST_PARITY;
            else           r_state <= ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_decide && (w_bit != w_par_exp)) r_perr <= 1'b1;
          if (w_wrap) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_decide) begin
            if (!w_bit) r_ferr <= 1'b1;
            if (r_idx == c_LAST_STOP) begin
              // Disarm so a held-low break line cannot start a new frame
              r_state <= ST_IDLE;
              r_armed <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_bus.data       = r_data;
  assign rx_bus.valid      = r_valid;
  assign rx_bus.parity_err = r_parity_err;
  assign rx_bus.frame_err  = r_frame_err;
  assign rx_bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next-generation serial-input block for the comm library. Configurable data width, parity mode and stop-bit count. Adds 3-sample majority voting, parity and framing error detection, and a valid/ready output register with overrun flag. Sits between the async rx pin and any byte-stream consumer (FIFO, command decoder).

Parameters:
p_CLK_DIV, 104, internal clock cycles per baud period; legal >= 8
p_DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
p_PARITY, 0, 0 = none, 1 = even, 2 = odd
p_STOP_BITS, 1, stop bits checked, 1 or 2

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_rx  in  1  serial line, asynchronous, idle high
i_ready  in  1  consumer accepts word when high with o_valid
o_data  out  p_DATA_BITS  received word
o_valid  out  1  o_data and flags hold an unconsumed word
o_parity_err  out  1  parity mismatch for the held word
o_frame_err  out  1  a stop bit was sampled low for the held word
o_overrun  out  1  sticky: a completed word was dropped because o_valid was high

Behaviour:
- Reset (async, active-high): state IDLE, counters 0, sync flops 1, o_data 0, o_valid 0, all flags 0. Reset mid-frame discards the partial frame; no o_valid is produced for it.
- i_rx passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised value rx_s.
- Baud counter runs 0..p_CLK_DIV-1 and then wraps. MID = p_CLK_DIV/2 (integer division).
- Samples are taken at counts MID-1, MID and MID+1. The bit value is the majority of the 3 samples, decided at count MID+1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s == 0, go to START. The counter is 0 on the first START cycle.
- START: at the decision point, majority 0 -> DATA with bit index 0; majority 1 -> IDLE (false start, no flags, no output).
- DATA: each decision stores the bit into shift position bit_index. After bit p_DATA_BITS-1, go to PARITY if p_PARITY != 0, otherwise go to STOP. Each state change happens at counter wrap, not at the decision point.
- PARITY: the decided bit is compared with the XOR of the data bits (even) or its inverse (odd). A mismatch sets an internal perr.
- STOP: each of p_STOP_BITS decisions must be 1; any 0 sets an internal ferr.
- Frame completion: at the decision point of the last stop bit, go to IDLE immediately, without waiting for the wrap. This allows back-to-back frames whose next start edge begins at the second half of the stop bit.
- Output register, cycle after completion:
  - If o_valid == 0, or i_ready == 1 on the completion cycle: load o_data, o_parity_err <= perr, o_frame_err <= ferr, o_valid <= 1.
  - Otherwise drop the new word and set o_overrun <= 1. The held word is unchanged.
- Handshake: o_valid && i_ready consumes the word. o_valid falls the next cycle unless a completion coincides in that cycle, in which case the new word loads and o_valid stays 1.
- o_overrun clears on the first handshake after it is set. o_data and flags stay stable while o_valid is high and unconsumed.
- Latency: o_valid rises 1 cycle after the last stop-bit decision. Measured from the start edge on i_rx, the decision point carries an additional 2-cycle synchroniser delay.
- A frame error with data all zero (break) is reported as a normal word with o_frame_err = 1. The receiver waits in IDLE until rx_s returns high before arming again; a held-low line must not retrigger START.
- Widths: bit index is $clog2(p_DATA_BITS+1) bits; the counter is $clog2(p_CLK_DIV) bits. No arithmetic overflow is possible inside the legal parameter ranges.

Decomposition:
- Shared package uart_pkg holds:
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - state encodings
  - a function computing MID from p_CLK_DIV
- One sub-module, uart_bit_sampler, contains the synchroniser, baud counter, 3-sample majority, and decision/wrap strobes.
- uart_rx_param contains the FSM, shift register, parity/stop checks and the output handshake register.

Test Plan:
- 8N1, p_CLK_DIV=16: send 0xA5, i_ready=1 -> one o_valid pulse, o_data=0xA5, o_parity_err=0, o_frame_err=0, o_overrun=0.
- 7E2: send 0x41 with parity bit 1 (wrong) -> o_data=0x41, o_parity_err=1. Repeat with parity 0 -> o_parity_err=0. Odd mode with 0x00, parity 1 -> no error.
- 8N1: send 0x3C with stop bit forced 0 -> o_frame_err=1, o_data=0x3C. Hold line low 20 bit periods -> exactly one word (0x00, frame_err=1), no retrigger until line high.
- Glitches:
  - 1-cycle low pulse on idle line -> no o_valid.
  - 1-cycle inverted glitch at MID of data bit 3 in 0x00 -> o_data=0x00 (majority rejects).
- Overrun: i_ready=0, send 0x11 then 0x22 back to back -> o_data=0x11, o_overrun=1. Assert i_ready for one cycle -> o_valid=0, o_overrun=0.
- Assert i_rst during data bit 4 of a frame -> all outputs 0 asynchronously. Release, send 0x5A -> o_data=0x5A received cleanly.
